// File: rtl/parity_serial_sched_if.sv
// rtl/parity_serial_sched_if.sv - requester, serial tap and result bundle for parity_serial_sched
interface parity_serial_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_par;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_par;
  logic             req1_ready;
  logic             ser_valid;
  logic             ser_data;
  logic             busy;
  logic             done_valid;
  logic             done_id;
  logic             done_parity;
  logic             done_err;
  logic [7:0]       err_cnt;

  // requester / observer side
  modport master (
    output req0_valid, req0_data, req0_par,
    output req1_valid, req1_data, req1_par,
    input  req0_ready, req1_ready,
    input  ser_valid, ser_data, busy,
    input  done_valid, done_id, done_parity, done_err, err_cnt
  );

  // scheduler side
  modport slave (
    input  req0_valid, req0_data, req0_par,
    input  req1_valid, req1_data, req1_par,
    output req0_ready, req1_ready,
    output ser_valid, ser_data, busy,
    output done_valid, done_id, done_parity, done_err, err_cnt
  );
endinterface

// File: rtl/parity_serial_sched.sv
// rtl/parity_serial_sched.sv - round-robin bit-serial parity scheduler for two requesters
module parity_serial_sched #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  parity_serial_sched_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             acc;
  logic             cap_par;
  logic             cap_id;

  logic             ser_valid_r;
  logic             done_valid_r;
  logic             done_id_r;
  logic             done_parity_r;
  logic             done_err_r;
  logic [7:0]       err_cnt_r;

  logic             grant0;
  logic             grant1;
  logic             ready0;
  logic             ready1;
  logic             par_next;
  logic             err_next;

  // Round-robin grant: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant0   = bus.req0_valid & (~bus.req1_valid |  last_grant);
    grant1   = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    ready0   = (state == IDLE) & grant0;
    ready1   = (state == IDLE) & grant1;
    // The last bit is folded in here so the result is ready on the final shift edge.
    par_next = acc ^ shreg[0] ^ ODD;
    err_next = par_next ^ cap_par;
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.ser_valid   = ser_valid_r;
  assign bus.ser_data    = ser_valid_r & shreg[0];
  assign bus.busy        = (state != IDLE);
  assign bus.done_valid  = done_valid_r;
  assign bus.done_id     = done_id_r;
  assign bus.done_parity = done_parity_r;
  assign bus.done_err    = done_err_r;
  assign bus.err_cnt     = err_cnt_r;

  // Scheduler FSM: accept a word, shift it out LSB first while accumulating parity, report once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      shreg         <= '0;
      bit_cnt       <= '0;
      acc           <= 1'b0;
      cap_par       <= 1'b0;
      cap_id        <= 1'b0;
      ser_valid_r   <= 1'b0;
      done_valid_r  <= 1'b0;
      done_id_r     <= 1'b0;
      done_parity_r <= 1'b0;
      done_err_r    <= 1'b0;
      err_cnt_r     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          done_valid_r <= 1'b0;
          if (ready0 || ready1) begin
            shreg       <= ready1 ? bus.req1_data : bus.req0_data;
            cap_par     <= ready1 ? bus.req1_par  : bus.req0_par;
            cap_id      <= ready1;
            last_grant  <= ready1;
            acc         <= 1'b0;
            bit_cnt     <= '0;
            ser_valid_r <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          acc     <= acc ^ shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            ser_valid_r   <= 1'b0;
            done_valid_r  <= 1'b1;
            done_id_r     <= cap_id;
            done_parity_r <= par_next;
            done_err_r    <= err_next;
            if (err_next && (err_cnt_r != 8'hFF)) begin
              err_cnt_r <= err_cnt_r + 8'd1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          done_valid_r <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          ser_valid_r  <= 1'b0;
          done_valid_r <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serial_sched.sv
// tb/tb_parity_serial_sched.sv - randomized self-checking bench for parity_serial_sched
module tb_parity_serial_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  // reference model state
  bit   m_last  = 1'b1;
  int   m_cnt_e = 0;
  int   m_cnt_o = 0;

  parity_serial_sched_if #(.WIDTH(8)) ife ();
  parity_serial_sched_if #(.WIDTH(8)) ifo ();

  parity_serial_sched #(.WIDTH(8), .ODD(1'b0)) dut_e (.clk(clk), .rst(rst), .bus(ife));
  parity_serial_sched #(.WIDTH(8), .ODD(1'b1)) dut_o (.clk(clk), .rst(rst), .bus(ifo));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    ife.req0_valid = 1'b0; ife.req1_valid = 1'b0;
    ife.req0_data = 8'h00; ife.req1_data = 8'h00;
    ife.req0_par = 1'b0;   ife.req1_par = 1'b0;
    ifo.req0_valid = 1'b0; ifo.req1_valid = 1'b0;
    ifo.req0_data = 8'h00; ifo.req1_data = 8'h00;
    ifo.req0_par = 1'b0;   ifo.req1_par = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", ife.busy, 0);
    chk("rst_ser_valid", ife.ser_valid, 0);
    chk("rst_ser_data", ife.ser_data, 0);
    chk("rst_done_valid", ife.done_valid, 0);
    chk("rst_done_id", ife.done_id, 0);
    chk("rst_done_parity", ife.done_parity, 0);
    chk("rst_done_err", ife.done_err, 0);
    chk("rst_err_cnt", ife.err_cnt, 0);
    chk("rst_ready0", ife.req0_ready, 0);
    chk("rst_ready1", ife.req1_ready, 0);
    chk("rst_odd_err_cnt", ifo.err_cnt, 0);
    rst = 1'b0;
    m_last = 1'b1; m_cnt_e = 0; m_cnt_o = 0;
  endtask

  // One full transaction on the even DUT; entered and left at posedge+1 of an IDLE cycle.
  // The loser of a tie keeps its valid asserted on exit.
  task automatic run_one(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                         input bit p0, input bit p1);
    bit win, ep, ee;
    logic [7:0] wd;
    bit wp;
    win = (v0 && v1) ? !m_last : v1;
    wd  = win ? d1 : d0;
    wp  = win ? p1 : p0;
    ep  = ^wd;
    ee  = ep ^ wp;
    ife.req0_valid = v0; ife.req0_data = d0; ife.req0_par = p0;
    ife.req1_valid = v1; ife.req1_data = d1; ife.req1_par = p1;
    #1;
    chk("ready0", ife.req0_ready, !win);
    chk("ready1", ife.req1_ready, win);
    chk("busy_idle", ife.busy, 0);
    @(posedge clk); #1;
    if (win) begin
      ife.req1_valid = 1'b0; ife.req1_data = 8'($urandom); ife.req1_par = 1'($urandom);
    end else begin
      ife.req0_valid = 1'b0; ife.req0_data = 8'($urandom); ife.req0_par = 1'($urandom);
    end
    m_last = win;
    if (ee && m_cnt_e < 255) m_cnt_e++;
    for (int i = 0; i < 8; i++) begin
      chk("ser_valid", ife.ser_valid, 1);
      chk("ser_data", ife.ser_data, wd[i]);
      chk("busy_shift", ife.busy, 1);
      chk("ready_busy", {ife.req0_ready, ife.req1_ready}, 0);
      chk("done_early", ife.done_valid, 0);
      @(posedge clk); #1;
    end
    chk("done_valid", ife.done_valid, 1);
    chk("done_id", ife.done_id, win);
    chk("done_parity", ife.done_parity, ep);
    chk("done_err", ife.done_err, ee);
    chk("err_cnt", ife.err_cnt, m_cnt_e);
    chk("ser_valid_done", ife.ser_valid, 0);
    @(posedge clk); #1;
    chk("done_pulse", ife.done_valid, 0);
    chk("busy_after", ife.busy, 0);
    chk("hold_id", ife.done_id, win);
    chk("hold_parity", ife.done_parity, ep);
    chk("hold_err", ife.done_err, ee);
  endtask

  // Single-requester transaction on the odd-parity DUT.
  task automatic run_odd(input logic [7:0] d, input bit p);
    bit ep, ee;
    ep = ~(^d);
    ee = ep ^ p;
    ifo.req0_valid = 1'b1; ifo.req0_data = d; ifo.req0_par = p;
    #1;
    chk("odd_ready0", ifo.req0_ready, 1);
    @(posedge clk); #1;
    ifo.req0_valid = 1'b0;
    if (ee && m_cnt_o < 255) m_cnt_o++;
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("odd_done_valid", ifo.done_valid, 1);
    chk("odd_done_parity", ifo.done_parity, ep);
    chk("odd_done_err", ifo.done_err, ee);
    chk("odd_err_cnt", ifo.err_cnt, m_cnt_o);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b5;
    bit v0, v1;
    b5 = 8'hB5;
    clear_inputs();
    do_reset();

    // basic word, then after reset a tie with the loser held valid
    run_one(1, 0, 8'hB5, 8'h00, 1, 0);
    do_reset();
    run_one(1, 1, 8'h0F, 8'h01, 0, 1);
    run_one(0, 1, 8'h00, 8'h01, 0, 1);

    // mismatch counting
    run_one(0, 1, 8'h00, 8'h00, 0, 1);
    run_one(1, 0, 8'h03, 8'h00, 0, 0);
    chk("err_cnt_after_ok", ife.err_cnt, 1);

    // odd parity sense
    run_odd(8'hFF, 1);
    for (int i = 0; i < 4; i++) run_odd(8'($urandom), 1'($urandom));

    // randomized contention and data
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_one(v0, v1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    clear_inputs();

    // saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      d = 8'($urandom);
      run_one(1, 0, d, 8'h00, ~(^d), 0);
    end
    chk("err_cnt_sat", ife.err_cnt, 255);
    clear_inputs();
    do_reset();

    // reset in the fourth shift cycle aborts the word
    ife.req0_valid = 1'b1; ife.req0_data = 8'hB5; ife.req0_par = 1'b1;
    @(posedge clk); #1;
    ife.req0_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_ser_valid", ife.ser_valid, 1);
    chk("abort_ser_data", ife.ser_data, b5[3]);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", ife.busy, 0);
    chk("abort_ser_off", ife.ser_valid, 0);
    chk("abort_done", ife.done_valid, 0);
    rst = 1'b0;
    m_last = 1'b1; m_cnt_e = 0; m_cnt_o = 0;
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", ife.done_valid, 0);
      @(posedge clk); #1;
    end
    run_one(1, 1, 8'h5A, 8'hC3, 0, 0);
    clear_inputs();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
